ps2_scan_decoder: RTL and testbench

//  Upstream feeder of the snake game core. Receives raw PS/2 keyboard frames on PS2_CLK/PS2_DAT,

---
 rtl/ps2_scan_decoder_if.sv | 22 ++
 rtl/ps2_scan_decoder.sv | 188 ++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_decoder_if.sv
// PS/2 keyboard line inputs and decoded key/byte outputs of ps2_scan_decoder.
// slave = the decoder, master = whatever drives the PS/2 lines and consumes the key outputs.
interface ps2_scan_decoder_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] key_value;
  logic       key_ext;
  logic       make_strobe;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output key_value, key_ext, make_strobe, byte_valid, byte_data, frame_err
  );

  modport master (
    output PS2_CLK, PS2_DAT,
    input  key_value, key_ext, make_strobe, byte_valid, byte_data, frame_err
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 frame receiver with E0/F0 prefix stripping; presents the currently held key.
// Define PS2_PARITY_CHECK_EN to drop bytes whose odd parity fails.
module ps2_scan_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                Clk,
  input  logic                Reset,
  ps2_scan_decoder_if.slave   ps2
);

  localparam int FW = (FILTER_LEN  > 1) ? $clog2(FILTER_LEN)  : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RX, S_DONE} state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt, r_clk_filt_d;
  logic [FW-1:0] r_flt_cnt;
  logic          w_fall;

  state_t        r_state, w_state_next;
  logic [3:0]    r_cnt;
  logic [7:0]    r_shift;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_ext, r_brk;
  logic [7:0]    r_key_value, r_byte_data;
  logic          r_key_ext, r_frame_err;

  logic          w_cnt_clr, w_cnt_inc, w_load_byte, w_err, w_clr_prefix, w_tmo_hit;
  logic          w_is_e0, w_is_f0;

`ifdef PS2_PARITY_CHECK_EN
  logic          r_parity;
  logic          w_par_ok;
  assign w_par_ok = ^{r_shift, r_parity};
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_clk_s1     <= 1'b0;
      r_clk_s2     <= 1'b0;
      r_dat_s1     <= 1'b0;
      r_dat_s2     <= 1'b0;
      r_clk_filt   <= 1'b0;
      r_clk_filt_d <= 1'b0;
      r_flt_cnt    <= '0;
    end else begin
      r_clk_s1     <= ps2.PS2_CLK;
      r_clk_s2     <= r_clk_s1;
      r_dat_s1     <= ps2.PS2_DAT;
      r_dat_s2     <= r_dat_s1;
      r_clk_filt_d <= r_clk_filt;
      // Filtered clock follows only after FILTER_LEN consecutive differing samples.
      if (r_clk_s2 == r_clk_filt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_filt <= r_clk_s2;
        r_flt_cnt  <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + FW'(1);
      end
    end
  end

  assign w_fall    = r_clk_filt_d & ~r_clk_filt;
  assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_load_byte  = 1'b0;
    w_err        = 1'b0;
    w_clr_prefix = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && !r_dat_s2) begin
          w_state_next = S_RX;
          w_cnt_clr    = 1'b1;
        end
      end
      S_RX: begin
        // A fall in the expiry cycle takes priority over the timeout.
        if (w_fall) begin
          if (r_cnt == 4'd9) begin
            if (!r_dat_s2) begin
              w_err        = 1'b1;
              w_state_next = S_IDLE;
            end
`ifdef PS2_PARITY_CHECK_EN
            else if (!w_par_ok) begin
              w_err        = 1'b1;
              w_state_next = S_IDLE;
            end
`endif
            else begin
              w_load_byte  = 1'b1;
              w_state_next = S_DONE;
            end
          end else begin
            w_cnt_inc = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_err        = 1'b1;
          w_clr_prefix = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_is_e0 = (r_byte_data == 8'hE0);
  assign w_is_f0 = (r_byte_data == 8'hF0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_tmo_cnt   <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_key_value <= '0;
      r_key_ext   <= 1'b0;
      r_byte_data <= '0;
      r_frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 4'd1;

      if (r_state == S_RX && w_fall && r_cnt < 4'd8)
        r_shift <= {r_dat_s2, r_shift[7:1]};
`ifdef PS2_PARITY_CHECK_EN
      if (r_state == S_RX && w_fall && r_cnt == 4'd8)
        r_parity <= r_dat_s2;
`endif

      if (r_state == S_RX && !w_fall) r_tmo_cnt <= r_tmo_cnt + TW'(1);
      else                            r_tmo_cnt <= '0;

      r_frame_err <= w_err;
      if (w_load_byte) r_byte_data <= r_shift;

      if (w_clr_prefix) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_state == S_DONE) begin
        if (w_is_e0) begin
          r_ext <= 1'b1;
        end else if (w_is_f0) begin
          r_brk <= 1'b1;
        end else if (r_brk) begin
          // Only the break of the currently held key releases it.
          if ({r_ext, r_byte_data} == {r_key_ext, r_key_value}) begin
            r_key_value <= '0;
            r_key_ext   <= 1'b0;
          end
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end else begin
          r_key_value <= r_byte_data;
          r_key_ext   <= r_ext;
          r_ext       <= 1'b0;
        end
      end
    end
  end

  assign ps2.key_value   = r_key_value;
  assign ps2.key_ext     = r_key_ext;
  assign ps2.byte_valid  = (r_state == S_DONE);
  assign ps2.byte_data   = r_byte_data;
  assign ps2.make_strobe = (r_state == S_DONE) && !w_is_e0 && !w_is_f0 && !r_brk;
  assign ps2.frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Randomised scoreboard bench for ps2_scan_decoder: a key-state model predicts bytes,
// make codes and frame errors; a monitor process pops and compares as the DUT reports them.
module tb_ps2_scan_decoder;
  localparam int FLT = 8;
  localparam int TMO = 1000;
  localparam int H   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_scan_decoder_if bus();

  ps2_scan_decoder #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TMO)) u_dut (
    .Clk   (clk),
    .Reset (rst),
    .ps2   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_bytes[$];
  logic [7:0] exp_makes[$];
  int         exp_errs = 0;

  // Reference key state: the held key plus pending prefix flags.
  logic [7:0] m_kv;
  logic       m_ke, m_ext, m_brk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_kv = 8'h00; m_ke = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_brk) begin
      if (m_ext == m_ke && b == m_kv) begin
        m_kv = 8'h00;
        m_ke = 1'b0;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_kv = b;
      m_ke = m_ext;
      m_ext = 1'b0;
      exp_makes.push_back(b);
    end
  endtask

  task automatic ps2_bit(input logic b);
    bus.PS2_DAT = b;
    wait_cyc(H);
    bus.PS2_CLK = 1'b0;
    wait_cyc(H);
    bus.PS2_CLK = 1'b1;
  endtask

  // Sends the first nbits of an 11-bit frame (start, 8 data LSB first, odd parity, stop).
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    logic        par;
    par = ~(^b) ^ bad_par;
    f   = {~bad_stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    bus.PS2_DAT = 1'b1;
    wait_cyc(24);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_bytes.push_back(b);
    model_byte(b);
    send_bits(b, 11, 1'b0, 1'b0);
  endtask

  task automatic check_key(input string tag);
    wait_cyc(4);
    check({tag, "_key_value"}, bus.key_value, m_kv);
    check({tag, "_key_ext"},   bus.key_ext,   m_ke);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key_value"},   bus.key_value,   0);
    check({tag, "_key_ext"},     bus.key_ext,     0);
    check({tag, "_make_strobe"}, bus.make_strobe, 0);
    check({tag, "_byte_valid"},  bus.byte_valid,  0);
    check({tag, "_byte_data"},   bus.byte_data,   0);
    check({tag, "_frame_err"},   bus.frame_err,   0);
  endtask

  // Monitor: every DUT pulse must match the next predicted event.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.byte_valid) begin
          if (exp_bytes.size() == 0) check("byte_unexpected", bus.byte_data, 32'hFFFF_FFFF);
          else                       check("byte_data", bus.byte_data, exp_bytes.pop_front());
        end
        if (bus.make_strobe) begin
          if (exp_makes.size() == 0) check("make_unexpected", bus.byte_data, 32'hFFFF_FFFF);
          else                       check("make_code", bus.byte_data, exp_makes.pop_front());
        end
        if (bus.frame_err) begin
          check("frame_err_expected", (exp_errs > 0), 1);
          if (exp_errs > 0) exp_errs--;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] keys [6];
    logic [7:0] k;
    keys = '{8'h75, 8'h74, 8'h72, 8'h6B, 8'h1C, 8'h29};

    rst = 1'b1;
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    model_reset();
    wait_cyc(5);
    check_all_zero("reset");
    rst = 1'b0;
    wait_cyc(30);

    // Single make 0x75.
    send_byte(8'h75);
    check_key("t1");

    // Extended make and its release.
    send_byte(8'hE0); send_byte(8'h74);
    check_key("t2_make");
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    check_key("t2_break");

    // Last key wins; a stale break is ignored.
    send_byte(8'h6B);
    check_key("t3_6b");
    send_byte(8'h72);
    check_key("t3_72");
    send_byte(8'hF0); send_byte(8'h6B);
    check_key("t3_stale");

    // Timeout mid-frame after an E0 prefix: prefix must be discarded.
    send_byte(8'hE0);
    exp_errs++;
    send_bits(8'h12, 6, 1'b0, 1'b0);
    wait_cyc(TMO + 100);
    check("t4_timeout_seen", exp_errs, 0);
    m_ext = 1'b0; m_brk = 1'b0;
    send_byte(8'h72);
    check_key("t4_after");

    // Bad stop bit: error, no byte.
    exp_errs++;
    send_bits(8'h29, 11, 1'b0, 1'b1);
    wait_cyc(10);
    check("t5_stop_err_seen", exp_errs, 0);
    check_key("t5_stop");

`ifdef PS2_PARITY_CHECK_EN
    exp_errs++;
    send_bits(8'h75, 11, 1'b1, 1'b0);
    wait_cyc(10);
    check("t5_parity_err_seen", exp_errs, 0);
    check_key("t5_parity");
`else
    exp_bytes.push_back(8'h75);
    model_byte(8'h75);
    send_bits(8'h75, 11, 1'b1, 1'b0);
    check_key("t5_parity_ignored");
`endif

    // Reset mid-frame.
    send_bits(8'h75, 5, 1'b0, 1'b0);
    rst = 1'b1;
    wait_cyc(3);
    check_all_zero("t6_reset");
    rst = 1'b0;
    model_reset();
    wait_cyc(30);
    send_byte(8'h75);
    check_key("t6_after");

    // Short clock glitches with data low must not start a frame.
    bus.PS2_DAT = 1'b0;
    for (int g = 0; g < 5; g++) begin
      bus.PS2_CLK = 1'b0;
      wait_cyc(3);
      bus.PS2_CLK = 1'b1;
      wait_cyc(20);
    end
    bus.PS2_DAT = 1'b1;
    wait_cyc(20);
    send_byte(8'h1C);
    check_key("glitch");

    // Random make/break traffic.
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 2) == 0 && m_kv != 8'h00 && !m_ke) k = m_kv;
      else k = keys[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) send_byte(8'hE0);
      if ($urandom_range(0, 2) == 0) send_byte(8'hF0);
      send_byte(k);
      check_key("rand");
    end

    wait_cyc(50);
    check("pending_bytes", exp_bytes.size(), 0);
    check("pending_makes", exp_makes.size(), 0);
    check("pending_errs",  exp_errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
